l1_threshold_servo: RTL and testbench

- Wishbone initiator that drives the L1 trigger threshold/rate target interface from the host side. Closed-loop servo: per-beam threshold write, threshold commit, one rate-counting period, count readback, threshold adjustment toward a target rate, repeat.
- Sits in the wb_clk_i domain, between the control fabric and the L1 trigger's threshold port. Replaces software polling.

---
 rtl/l1_trigger_pkg.sv | 74 +++++++
 rtl/wb_single_xfer.sv | 84 ++++++++
 rtl/l1_threshold_servo.sv | 247 ++++++++++++++++++++++++
 tb/tb_l1_threshold_servo.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_trigger_pkg.sv
// Shared definitions for the L1 trigger threshold port: address map,
// control bits, field widths, servo state encoding and the threshold step rule.
package l1_trigger_pkg;

  localparam int THRESH_W = 18;
  localparam int COUNT_W  = 32;
  localparam int ADR_W    = 22;

  localparam logic [ADR_W-1:0] CTRL_ADR   = 22'h000;
  localparam logic [ADR_W-1:0] THR_BASE   = 22'h100;
  localparam logic [ADR_W-1:0] STAGE_BASE = 22'h200;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_COMMIT_BIT = 1;
  localparam int CTRL_DONE_BIT   = 0;

  localparam logic [3:0] SEL_START  = 4'b0001;
  localparam logic [3:0] SEL_COMMIT = 4'b0010;
  localparam logic [3:0] SEL_THR    = 4'b0111;
  localparam logic [3:0] SEL_STAGE  = 4'b0010;
  localparam logic [3:0] SEL_READ   = 4'b1111;

  localparam logic [THRESH_W-1:0] THRESH_MAX = 18'h3FFFF;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_WR_THR = 4'd1,
    S_STAGE  = 4'd2,
    S_COMMIT = 4'd3,
    S_START  = 4'd4,
    S_GAP    = 4'd5,
    S_POLL   = 4'd6,
    S_RD_CNT = 4'd7,
    S_ADJUST = 4'd8
  } servo_state_e;

  // One servo step; the band is computed in 33 bits so target +/- tolerance never wraps.
  function automatic logic [THRESH_W-1:0] servo_adjust(
    input logic [THRESH_W-1:0] thr,
    input logic [COUNT_W-1:0]  count,
    input logic [COUNT_W-1:0]  target,
    input logic [COUNT_W-1:0]  tol,
    input logic [THRESH_W-1:0] step
  );
    logic [COUNT_W:0]    hi_s;
    logic [COUNT_W:0]    lo_s;
    logic [THRESH_W:0]   sum_s;
    logic [THRESH_W-1:0] res_s;
    hi_s  = {1'b0, target} + {1'b0, tol};
    if (target >= tol) begin
      lo_s = {1'b0, target} - {1'b0, tol};
    end else begin
      lo_s = 33'd0;
    end
    sum_s = {1'b0, thr} + {1'b0, step};
    if ({1'b0, count} > hi_s) begin
      if (sum_s > {1'b0, THRESH_MAX}) begin
        res_s = THRESH_MAX;
      end else begin
        res_s = sum_s[THRESH_W-1:0];
      end
    end else if ({1'b0, count} < lo_s) begin
      if (thr > step) begin
        res_s = thr - step;
      end else begin
        res_s = 18'd0;
      end
    end else begin
      res_s = thr;
    end
    return res_s;
  endfunction

endpackage

// File: rtl/wb_single_xfer.sv
// Single-transaction Wishbone initiator: launches one cycle per request,
// holds it until ack/err/rty or timeout, then reports done or fail for one clock.
module wb_single_xfer
  import l1_trigger_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             req_we,
  input  logic [ADR_W-1:0] req_adr,
  input  logic [31:0]      req_dat,
  input  logic [3:0]       req_sel,
  output logic             done,
  output logic             fail,
  output logic [31:0]      rdata,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [ADR_W-1:0] adr_o,
  output logic [31:0]      dat_o,
  output logic [3:0]       sel_o,
  input  logic [31:0]      dat_i,
  input  logic             ack_i,
  input  logic             err_i,
  input  logic             rty_i
);

  logic             cyc_r;
  logic             we_r;
  logic [ADR_W-1:0] adr_r;
  logic [31:0]      dat_r;
  logic [3:0]       sel_r;
  logic [15:0]      tmo_cnt_r;
  logic             tmo_s;
  logic             resp_s;

  assign tmo_s  = cyc_r & (tmo_cnt_r == 16'(ACK_TIMEOUT - 1));
  assign resp_s = ack_i | err_i | rty_i | tmo_s;
  // An error or retry outranks a simultaneous ack.
  assign fail   = cyc_r & (err_i | rty_i | (tmo_s & ~ack_i));
  assign done   = cyc_r & ack_i & ~err_i & ~rty_i;
  // Read data is valid alongside done; the servo registers it on that ack edge.
  assign rdata  = dat_i;

  assign cyc_o = cyc_r;
  assign stb_o = cyc_r;
  assign we_o  = we_r;
  assign adr_o = adr_r;
  assign dat_o = dat_r;
  assign sel_o = sel_r;

  // Bus cycle launch, hold, timeout count and drop after the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_r     <= 1'b0;
      we_r      <= 1'b0;
      adr_r     <= 22'd0;
      dat_r     <= 32'd0;
      sel_r     <= 4'd0;
      tmo_cnt_r <= 16'd0;
    end else if (cyc_r) begin
      if (resp_s) begin
        cyc_r     <= 1'b0;
        we_r      <= 1'b0;
        adr_r     <= 22'd0;
        dat_r     <= 32'd0;
        sel_r     <= 4'd0;
        tmo_cnt_r <= 16'd0;
      end else begin
        tmo_cnt_r <= tmo_cnt_r + 16'd1;
      end
    end else if (req) begin
      cyc_r     <= 1'b1;
      we_r      <= req_we;
      adr_r     <= req_adr;
      dat_r     <= req_dat;
      sel_r     <= req_sel;
      tmo_cnt_r <= 16'd0;
    end
  end

endmodule

// File: rtl/l1_threshold_servo.sv
// Closed-loop threshold servo: writes and commits per-beam thresholds, runs one
// rate-counting period, reads the counts back and steps thresholds toward the target.
module l1_threshold_servo
  import l1_trigger_pkg::*;
#(
  parameter int NBEAMS          = 2,
  parameter int POLL_GAP_CLOCKS = 64,
  parameter int ACK_TIMEOUT     = 255
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_ni,
  output logic                         wb_threshold_cyc_o,
  output logic                         wb_threshold_stb_o,
  output logic                         wb_threshold_we_o,
  output logic [ADR_W-1:0]             wb_threshold_adr_o,
  output logic [31:0]                  wb_threshold_dat_o,
  output logic [3:0]                   wb_threshold_sel_o,
  input  logic [31:0]                  wb_threshold_dat_i,
  input  logic                         wb_threshold_ack_i,
  input  logic                         wb_threshold_err_i,
  input  logic                         wb_threshold_rty_i,
  input  logic                         run_i,
  input  logic [COUNT_W-1:0]           target_rate_i,
  input  logic [COUNT_W-1:0]           tolerance_i,
  input  logic [THRESH_W-1:0]          step_i,
  input  logic [THRESH_W-1:0]          init_threshold_i,
  output logic [NBEAMS*THRESH_W-1:0]   threshold_o,
  output logic [NBEAMS*COUNT_W-1:0]    count_o,
  output logic                         busy_o,
  output logic                         iter_done_o,
  output logic                         err_o
);

  localparam int BW = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;
  localparam logic [BW-1:0] LAST_BEAM = BW'(NBEAMS - 1);
  localparam logic [31:0] START_DAT  = 32'd1 << CTRL_START_BIT;
  localparam logic [31:0] COMMIT_DAT = 32'd1 << CTRL_COMMIT_BIT;

  servo_state_e        state_r;
  servo_state_e        state_s;
  logic [BW-1:0]       beam_r;
  logic [THRESH_W-1:0] thr_r [NBEAMS];
  logic [COUNT_W-1:0]  cnt_r [NBEAMS];
  logic [15:0]         gap_cnt_r;
  logic                run_q_r;
  logic                err_r;
  logic                busy_r;
  logic                iter_done_r;

  logic                run_rise_s;
  logic                last_beam_s;
  logic                gap_end_s;
  logic                req_s;
  logic                req_we_s;
  logic [ADR_W-1:0]    req_adr_s;
  logic [31:0]         req_dat_s;
  logic [3:0]          req_sel_s;
  logic                xfer_done_s;
  logic                xfer_fail_s;
  logic [31:0]         xfer_rdata_s;

  assign run_rise_s  = run_i & ~run_q_r;
  assign last_beam_s = (beam_r == LAST_BEAM);
  assign gap_end_s   = (gap_cnt_r == 16'(POLL_GAP_CLOCKS - 1));

  wb_single_xfer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_xfer (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .req     (req_s),
    .req_we  (req_we_s),
    .req_adr (req_adr_s),
    .req_dat (req_dat_s),
    .req_sel (req_sel_s),
    .done    (xfer_done_s),
    .fail    (xfer_fail_s),
    .rdata   (xfer_rdata_s),
    .cyc_o   (wb_threshold_cyc_o),
    .stb_o   (wb_threshold_stb_o),
    .we_o    (wb_threshold_we_o),
    .adr_o   (wb_threshold_adr_o),
    .dat_o   (wb_threshold_dat_o),
    .sel_o   (wb_threshold_sel_o),
    .dat_i   (wb_threshold_dat_i),
    .ack_i   (wb_threshold_ack_i),
    .err_i   (wb_threshold_err_i),
    .rty_i   (wb_threshold_rty_i)
  );

  // Servo state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; any bus failure abandons the iteration.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:   if (run_rise_s) state_s = S_WR_THR; else state_s = S_IDLE;
      S_WR_THR: if (xfer_fail_s) state_s = S_IDLE;
                else if (xfer_done_s) state_s = S_STAGE;
                else state_s = S_WR_THR;
      S_STAGE:  if (xfer_fail_s) state_s = S_IDLE;
                else if (xfer_done_s) state_s = last_beam_s ? S_COMMIT : S_WR_THR;
                else state_s = S_STAGE;
      S_COMMIT: if (xfer_fail_s) state_s = S_IDLE;
                else if (xfer_done_s) state_s = S_START;
                else state_s = S_COMMIT;
      S_START:  if (xfer_fail_s) state_s = S_IDLE;
                else if (xfer_done_s) state_s = S_GAP;
                else state_s = S_START;
      S_GAP:    if (gap_end_s) state_s = S_POLL; else state_s = S_GAP;
      S_POLL:   if (xfer_fail_s) state_s = S_IDLE;
                else if (xfer_done_s) state_s = xfer_rdata_s[CTRL_DONE_BIT] ? S_RD_CNT : S_GAP;
                else state_s = S_POLL;
      S_RD_CNT: if (xfer_fail_s) state_s = S_IDLE;
                else if (xfer_done_s) state_s = last_beam_s ? S_ADJUST : S_RD_CNT;
                else state_s = S_RD_CNT;
      S_ADJUST: if (run_i) state_s = S_WR_THR; else state_s = S_IDLE;
      default:  state_s = S_IDLE;
    endcase
  end

  // Transaction request presented to the initiator in each bus state.
  always_comb begin
    req_s     = 1'b0;
    req_we_s  = 1'b0;
    req_adr_s = CTRL_ADR;
    req_dat_s = 32'd0;
    req_sel_s = 4'd0;
    case (state_r)
      S_WR_THR: begin
        req_s     = 1'b1;
        req_we_s  = 1'b1;
        req_adr_s = THR_BASE + ADR_W'(beam_r);
        req_dat_s = {{(32-THRESH_W){1'b0}}, thr_r[beam_r]};
        req_sel_s = SEL_THR;
      end
      S_STAGE: begin
        req_s     = 1'b1;
        req_we_s  = 1'b1;
        req_adr_s = STAGE_BASE + ADR_W'(beam_r);
        req_dat_s = 32'd1;
        req_sel_s = SEL_STAGE;
      end
      S_COMMIT: begin
        req_s     = 1'b1;
        req_we_s  = 1'b1;
        req_dat_s = COMMIT_DAT;
        req_sel_s = SEL_COMMIT;
      end
      S_START: begin
        req_s     = 1'b1;
        req_we_s  = 1'b1;
        req_dat_s = START_DAT;
        req_sel_s = SEL_START;
      end
      S_POLL: begin
        req_s     = 1'b1;
        req_sel_s = SEL_READ;
      end
      S_RD_CNT: begin
        req_s     = 1'b1;
        req_adr_s = THR_BASE + ADR_W'(beam_r);
        req_sel_s = SEL_READ;
      end
      default: begin
        req_s = 1'b0;
      end
    endcase
  end

  // Beam index, thresholds, counts, poll gap timer and status flags.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      run_q_r     <= 1'b0;
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
      iter_done_r <= 1'b0;
      beam_r      <= {BW{1'b0}};
      gap_cnt_r   <= 16'd0;
      for (int i = 0; i < NBEAMS; i++) begin
        thr_r[i] <= 18'd0;
        cnt_r[i] <= 32'd0;
      end
    end else begin
      run_q_r     <= run_i;
      busy_r      <= (state_s != S_IDLE);
      iter_done_r <= (state_r == S_ADJUST);
      gap_cnt_r   <= (state_r == S_GAP) ? gap_cnt_r + 16'd1 : 16'd0;
      if (xfer_fail_s) begin
        err_r <= 1'b1;
      end
      case (state_r)
        S_IDLE: begin
          if (run_rise_s) begin
            for (int i = 0; i < NBEAMS; i++) begin
              thr_r[i] <= init_threshold_i;
            end
            err_r  <= 1'b0;
            beam_r <= {BW{1'b0}};
          end
        end
        S_STAGE: begin
          if (xfer_done_s) begin
            beam_r <= last_beam_s ? {BW{1'b0}} : beam_r + BW'(1);
          end
        end
        S_POLL: begin
          if (xfer_done_s) begin
            beam_r <= {BW{1'b0}};
          end
        end
        S_RD_CNT: begin
          if (xfer_done_s) begin
            cnt_r[beam_r] <= xfer_rdata_s;
            beam_r        <= last_beam_s ? {BW{1'b0}} : beam_r + BW'(1);
          end
        end
        S_ADJUST: begin
          for (int i = 0; i < NBEAMS; i++) begin
            thr_r[i] <= servo_adjust(thr_r[i], cnt_r[i], target_rate_i, tolerance_i, step_i);
          end
          beam_r <= {BW{1'b0}};
        end
        default: begin
          beam_r <= beam_r;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NBEAMS; g++) begin : g_out
    assign threshold_o[g*THRESH_W +: THRESH_W] = thr_r[g];
    assign count_o[g*COUNT_W +: COUNT_W]       = cnt_r[g];
  end

  assign busy_o      = busy_r;
  assign iter_done_o = iter_done_r;
  assign err_o       = err_r;

endmodule

// File: tb/tb_l1_threshold_servo.sv
// Directed plus randomized checks of the threshold servo against a behavioural
// Wishbone target and a plain-arithmetic model of the threshold update rule.
`timescale 1ns/1ps
module tb_l1_threshold_servo;

  localparam int NB = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [21:0] adr;
  logic [31:0] dat_o;
  logic [3:0]  sel;
  logic [31:0] dat_i = 32'd0;
  logic        ack = 1'b0, err = 1'b0, rty = 1'b0;
  logic        run;
  logic [31:0] target, tol;
  logic [17:0] step, init_thr;
  logic [35:0] thr_o;
  logic [63:0] cnt_o;
  logic        busy, iter_done, err_o;

  always #5 clk = ~clk;

  l1_threshold_servo #(.NBEAMS(NB), .POLL_GAP_CLOCKS(64), .ACK_TIMEOUT(255)) dut (
    .wb_clk_i           (clk),
    .wb_rst_ni          (rst_n),
    .wb_threshold_cyc_o (cyc),
    .wb_threshold_stb_o (stb),
    .wb_threshold_we_o  (we),
    .wb_threshold_adr_o (adr),
    .wb_threshold_dat_o (dat_o),
    .wb_threshold_sel_o (sel),
    .wb_threshold_dat_i (dat_i),
    .wb_threshold_ack_i (ack),
    .wb_threshold_err_i (err),
    .wb_threshold_rty_i (rty),
    .run_i              (run),
    .target_rate_i      (target),
    .tolerance_i        (tol),
    .step_i             (step),
    .init_threshold_i   (init_thr),
    .threshold_o        (thr_o),
    .count_o            (cnt_o),
    .busy_o             (busy),
    .iter_done_o        (iter_done),
    .err_o              (err_o)
  );

  typedef struct packed {
    logic [21:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] gap;
  } txn_t;

  txn_t        log_q[$];
  txn_t        snap;
  logic        in_txn = 1'b0;
  int          mode = 0;        // 0 ack all, 1 never respond, 2 err on stage writes
  int          poll_need = 3;
  int          poll_seen = 0;
  int          gap_run = 0;
  int          unstable = 0;
  int          iter_cnt = 0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] cnt_tab [NB];

  logic [21:0] e_adr [11] = '{22'h100, 22'h200, 22'h101, 22'h201, 22'h000, 22'h000,
                              22'h000, 22'h000, 22'h000, 22'h100, 22'h101};
  logic [31:0] e_dat [6]  = '{32'd1000, 32'd1, 32'd1000, 32'd1, 32'd2, 32'd1};
  logic [3:0]  e_sel [6]  = '{4'b0111, 4'b0010, 4'b0111, 4'b0010, 4'b0010, 4'b0001};

  // Behavioural target: logs every bus cycle, answers it half a clock after it starts.
  always @(negedge clk) begin
    ack = 1'b0;
    err = 1'b0;
    rty = 1'b0;
    if (cyc && stb) begin
      if (!in_txn) begin
        in_txn = 1'b1;
        snap = '{adr: adr, dat: dat_o, sel: sel, we: we, gap: gap_run};
        log_q.push_back(snap);
        gap_run = 0;
        if (we && adr == 22'h0 && dat_o == 32'd1) poll_seen = 0;
        if (mode == 0 || (mode == 2 && !(we && adr[21:8] == 14'd2))) begin
          ack = 1'b1;
          if (!we && adr == 22'h0) begin
            poll_seen++;
            dat_i = 32'hA5A5_A5A4 | ((poll_seen >= poll_need) ? 32'd1 : 32'd0);
          end else if (!we) begin
            dat_i = cnt_tab[adr[0]];
          end else begin
            dat_i = 32'd0;
          end
        end else if (mode == 2) begin
          err = 1'b1;
        end
      end else if (adr !== snap.adr || dat_o !== snap.dat || sel !== snap.sel || we !== snap.we) begin
        unstable++;
      end
    end else begin
      in_txn = 1'b0;
      gap_run++;
    end
    if (iter_done) iter_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic longint model_thr(longint thr, longint cnt, longint tg, longint tl, longint st);
    longint hi = tg + tl;
    longint lo = tg - tl;
    if (lo < 0) lo = 0;
    if (cnt > hi) return (thr + st > 262143) ? 262143 : thr + st;
    if (cnt < lo) return (thr < st) ? 0 : thr - st;
    return thr;
  endfunction

  task automatic wait_iter(input string tag);
    int n = 0;
    while (iter_done !== 1'b1 && n < 6000) begin
      tick(1);
      n++;
    end
    chk(tag, 64'(n < 6000), 64'd1);
  endtask

  // One full iteration from a run_i pulse; thresholds and counts checked against the model.
  task automatic run_once(input string tag, input longint i0, input longint tg, input longint tl,
                          input longint st, input longint c0, input longint c1);
    longint e0, e1;
    init_thr = 18'(i0);
    target = 32'(tg);
    tol = 32'(tl);
    step = 18'(st);
    cnt_tab[0] = 32'(c0);
    cnt_tab[1] = 32'(c1);
    run = 1'b1;
    tick(3);
    run = 1'b0;
    wait_iter({tag, "_wait"});
    e0 = model_thr(i0, c0, tg, tl, st);
    e1 = model_thr(i0, c1, tg, tl, st);
    chk({tag, "_thr"}, 64'(thr_o), 64'({18'(e1), 18'(e0)}));
    chk({tag, "_cnt"}, cnt_o, {32'(c1), 32'(c0)});
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    tick(2);
  endtask

  initial begin
    int n;
    int hold;
    rst_n = 1'b0;
    run = 1'b0;
    target = 32'd100;
    tol = 32'd10;
    step = 18'd16;
    init_thr = 18'd1000;
    cnt_tab[0] = 32'd150;
    cnt_tab[1] = 32'd50;
    tick(3);
    chk("rst_cyc", 64'({cyc, stb, we}), 64'd0);
    chk("rst_bus", 64'({adr, sel}), 64'd0);
    chk("rst_dat", 64'(dat_o), 64'd0);
    chk("rst_thr", 64'(thr_o), 64'd0);
    chk("rst_cnt", cnt_o, 64'd0);
    chk("rst_flags", 64'({busy, iter_done, err_o}), 64'd0);
    rst_n = 1'b1;
    tick(2);

    // First iteration: exact bus sequence, then servo step 150/50 against 100 +/- 10.
    log_q.delete();
    run = 1'b1;
    wait_iter("it1_wait");
    chk("it1_thr", 64'(thr_o), 64'({18'd984, 18'd1016}));
    chk("it1_cnt", cnt_o, {32'd50, 32'd150});
    chk("it1_len", 64'(log_q.size()), 64'd11);
    for (int i = 0; i < 11 && i < log_q.size(); i++) begin
      chk($sformatf("seq%0d_adr", i), 64'(log_q[i].adr), 64'(e_adr[i]));
      chk($sformatf("seq%0d_we", i), 64'(log_q[i].we), 64'(i < 6));
      if (i < 6) begin
        chk($sformatf("seq%0d_dat", i), 64'(log_q[i].dat), 64'(e_dat[i]));
        chk($sformatf("seq%0d_sel", i), 64'(log_q[i].sel), 64'(e_sel[i]));
      end
      if (i > 0 && i < 6) chk($sformatf("seq%0d_gap", i), 64'(log_q[i].gap), 64'd1);
    end
    cnt_tab[0] = 32'd110;
    cnt_tab[1] = 32'd90;
    log_q.delete();

    // Second iteration writes the stepped thresholds; run_i drops mid-iteration.
    n = 0;
    while (log_q.size() < 3 && n < 500) begin
      tick(1);
      n++;
    end
    chk("it2_start", 64'(log_q.size() >= 3), 64'd1);
    chk("it1_pulses", 64'(iter_cnt), 64'd1);
    if (log_q.size() >= 3) begin
      chk("it2_w0", 64'({log_q[0].adr, log_q[0].dat}), 64'({22'h100, 32'd1016}));
      chk("it2_w1", 64'({log_q[2].adr, log_q[2].dat}), 64'({22'h101, 32'd984}));
    end
    run = 1'b0;
    wait_iter("it2_wait");
    chk("band_thr", 64'(thr_o), 64'({18'd984, 18'd1016}));
    chk("band_cnt", cnt_o, {32'd90, 32'd110});
    chk("it2_len", 64'(log_q.size()), 64'd11);
    tick(3);
    chk("it2_pulses", 64'(iter_cnt), 64'd2);
    chk("it2_idle", 64'({busy, cyc}), 64'd0);
    chk("stable", 64'(unstable), 64'd0);

    // Saturation at both ends and 33-bit band arithmetic.
    poll_need = 1;
    run_once("sat_hi", 64'h3FFF8, 100, 10, 16, 1000, 0);
    run_once("sat_lo", 5, 100, 10, 16, 1000, 0);
    run_once("wide_hi", 1000, 64'hFFFF_FFF0, 64'h20, 16, 64'hFFFF_FFFF, 64'hFFFF_FFD0);
    run_once("tol_gt_tgt", 1000, 5, 10, 16, 0, 16);

    // Target that never responds: strobes held exactly ACK_TIMEOUT clocks.
    mode = 1;
    log_q.delete();
    run = 1'b1;
    n = 0;
    while (cyc !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    chk("tmo_start", 64'(cyc), 64'd1);
    hold = 0;
    while (cyc === 1'b1 && hold < 400) begin
      hold++;
      tick(1);
    end
    chk("tmo_hold", 64'(hold), 64'd255);
    chk("tmo_err", 64'(err_o), 64'd1);
    chk("tmo_idle", 64'({busy, cyc, stb}), 64'd0);
    chk("tmo_stable", 64'(unstable), 64'd0);

    // err_i on the stage write; the next run_i rising edge clears err_o.
    run = 1'b0;
    tick(2);
    mode = 2;
    log_q.delete();
    run = 1'b1;
    tick(2);
    chk("err_clear1", 64'(err_o), 64'd0);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      tick(1);
      n++;
    end
    tick(4);
    chk("berr_err", 64'(err_o), 64'd1);
    chk("berr_idle", 64'({busy, cyc}), 64'd0);
    chk("berr_len", 64'(log_q.size()), 64'd2);
    if (log_q.size() >= 2) chk("berr_adr", 64'(log_q[1].adr), 64'h200);
    run = 1'b0;
    mode = 0;
    tick(2);
    run = 1'b1;
    tick(2);
    chk("err_clear2", 64'(err_o), 64'd0);
    run = 1'b0;
    wait_iter("berr_recover");
    tick(2);

    // Asynchronous reset in the middle of a done-flag poll.
    poll_need = 1000;
    run = 1'b1;
    n = 0;
    while (!(cyc === 1'b1 && we === 1'b0 && adr === 22'h0) && n < 3000) begin
      tick(1);
      n++;
    end
    chk("poll_seen", 64'(cyc), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cyc", 64'({cyc, stb}), 64'd0);
    chk("arst_thr", 64'(thr_o), 64'd0);
    chk("arst_cnt", cnt_o, 64'd0);
    chk("arst_flags", 64'({busy, iter_done, err_o, we}), 64'd0);
    run = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    poll_need = 2;
    run_once("post_rst", 2000, 500, 50, 100, 600, 400);

    // Randomized iterations against the model.
    for (int k = 0; k < 8; k++) begin
      poll_need = int'($urandom_range(1, 3));
      run_once($sformatf("rnd%0d", k), longint'($urandom_range(0, 262143)),
               longint'($urandom_range(0, 3000)), longint'($urandom_range(0, 400)),
               longint'($urandom_range(0, 40000)), longint'($urandom_range(0, 4000)),
               longint'($urandom_range(0, 4000)));
    end
    chk("final_stable", 64'(unstable), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
